// File: rtl/conv_pkg.sv
// Shared constants and FSM state encoding for the convolution MAC stage.
// All widths derive from here; TAPS must stay a power of two so history indices wrap naturally.
package conv_pkg;
    localparam int N_W    = 16;
    localparam int ADDR_W = 6;
    localparam int TAPS   = 32;
    localparam int ACC_W  = 40;
    localparam int TAP_W  = $clog2(TAPS);
    localparam int PROD_W = 2 * N_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/conv_mac_if.sv
// Sample input, coefficient ROM port and result output of conv_mac bundled as one interface.
// slave is the datapath view; master is the view of whatever drives samples and consumes results.
interface conv_mac_if;
    import conv_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [N_W-1:0]    in_data;
    logic [ADDR_W-1:0] coef_addr;
    logic [N_W-1:0]    coef_data;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;

    modport slave (
        input  in_valid, in_data, coef_data, out_ready,
        output in_ready, coef_addr, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, coef_data, out_ready,
        input  in_ready, coef_addr, out_valid, out_data
    );
endinterface

// File: rtl/conv_delay_line.sv
// Circular sample history: one write per accepted sample, read combinationally at (newest - offset).
// Zero latency read; the write pointer already points past the newest sample once it is written.
module conv_delay_line
    import conv_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [N_W-1:0]   wdata_i,
    input  logic [TAP_W-1:0] rd_off_i,
    output logic [N_W-1:0]   rdata_o
);
    logic [N_W-1:0]   hist_q [TAPS];
    logic [TAP_W-1:0] wptr_q;
    logic [TAP_W-1:0] wptr_d;
    logic [TAP_W-1:0] newest;
    logic [TAP_W-1:0] rd_idx;

    assign wptr_d  = wptr_q + 1'b1;
    assign newest  = wptr_q - 1'b1;
    assign rd_idx  = newest - rd_off_i;
    assign rdata_o = hist_q[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            for (int i = 0; i < TAPS; i++) begin
                hist_q[i] <= '0;
            end
        end else if (we_i) begin
            hist_q[wptr_q] <= wdata_i;
            wptr_q         <= wptr_d;
        end
    end
endmodule

// File: rtl/conv_mac.sv
// Convolution MAC: accepts one sample, walks ROM taps 0..TAPS-1, presents the full-precision sum.
// Result valid TAPS+1 cycles after accept; held stable under out_ready backpressure, no new input until drained.
module conv_mac
    import conv_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    conv_mac_if.slave bus
);
    state_t                   state_q;
    logic [TAP_W-1:0]         k_q;
    logic [TAP_W-1:0]         k_d;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic                     in_ready_q;
    logic                     out_valid_q;
    logic                     accept;
    logic [N_W-1:0]           x_dat;
    logic signed [PROD_W-1:0] prod;

    assign accept = bus.in_valid && in_ready_q;

    conv_delay_line u_hist (
        .clk      (clk),
        .rst      (rst),
        .we_i     (accept),
        .wdata_i  (bus.in_data),
        .rd_off_i (k_q),
        .rdata_o  (x_dat)
    );

    assign prod  = $signed(bus.coef_data) * $signed(x_dat);
    assign acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign k_d   = k_q + 1'b1;

    // k_q wraps back to zero at the end of MAC, so the address is already 0 in IDLE/DONE.
    assign bus.coef_addr = {{(ADDR_W-TAP_W){1'b0}}, k_q};
    assign bus.in_ready  = in_ready_q && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q    <= MAC;
                        k_q        <= '0;
                        acc_q      <= '0;
                        in_ready_q <= 1'b0;
                    end
                end
                MAC: begin
                    acc_q <= acc_d;
                    k_q   <= k_d;
                    if (k_q == TAP_W'(TAPS - 1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    k_q         <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_conv_mac.sv
// Directed bench for conv_mac: models the 64x16 coefficient ROM and checks results against hand-computed sums.
module tb_conv_mac;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_mac_if bus ();

    conv_mac dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Symmetric 32-tap low-pass; taps 0..15 listed, 16..31 mirror them. Sum of all taps = 3730.
    int half_tab [16] = '{-15, -47, -76, -97, -100, -90, -60, -15,
                          40, 105, 175, 245, 350, 450, 491, 509};

    logic [15:0] rom [64];
    assign bus.coef_data = rom[bus.coef_addr];

    int n_vec = 0;
    int n_bad = 0;

    function automatic int coef(input int i);
        return (i < 16) ? half_tab[i] : half_tab[31 - i];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] v);
        bus.in_data  = v;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 100 && bus.in_ready !== 1'b1; i++) tick();
        chk("in_ready_seen", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
        chk("out_valid_seen", bus.out_valid, 1);
    endtask

    task automatic xfer(input logic [15:0] v, output logic signed [63:0] res);
        int lat;
        send(v);
        wait_out(lat);
        res = $signed(bus.out_data);
        if (bus.out_ready) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic signed [63:0] r;
        int lat;
        int stale;

        for (int i = 0; i < 64; i++) rom[i] = (i < 32) ? 16'(coef(i)) : 16'h7FFF;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        // Reset state
        tick();
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", $signed(bus.out_data), 0);
        chk("rst_coef_addr", bus.coef_addr, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", bus.in_ready, 1);
        chk("post_rst_out_valid", bus.out_valid, 0);

        // First impulse sample with cycle-exact latency and address stepping
        bus.in_data  = 16'd1;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("in_ready_mac", bus.in_ready, 0);
        for (int k = 0; k < 32; k++) begin
            chk("coef_addr_step", bus.coef_addr, k);
            chk("out_valid_early", bus.out_valid, 0);
            tick();
        end
        chk("latency_t33", bus.out_valid, 1);
        chk("impulse_0", $signed(bus.out_data), -15);
        chk("done_coef_addr", bus.coef_addr, 0);
        chk("done_in_ready", bus.in_ready, 0);
        tick();
        chk("hs_out_valid", bus.out_valid, 0);
        chk("idle_in_ready", bus.in_ready, 1);

        // Rest of the impulse response
        for (int i = 1; i < 32; i++) begin
            xfer(16'd0, r);
            chk("impulse", r, coef(i));
        end

        // Step: partial sums of taps, full sum on the 32nd
        for (int i = 0; i < 32; i++) begin
            xfer(16'd1, r);
            if (i == 0)  chk("step_1", r, -15);
            if (i == 15) chk("step_16", r, 1865);
            if (i == 31) chk("step_32", r, 3730);
        end

        // Extreme negative samples
        for (int i = 0; i < 32; i++) begin
            xfer(16'h8000, r);
            if (i == 0)  chk("extreme_1", r, 495265);
            if (i == 31) chk("extreme_32", r, -122224640);
        end

        // Backpressure in DONE with a competing input held
        bus.out_ready = 1'b0;
        send(16'd0);
        wait_out(lat);
        chk("latency_bp", lat, 33);
        bus.in_data  = 16'd2;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_out_data", $signed(bus.out_data), -122716160);
            chk("bp_in_ready", bus.in_ready, 0);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        chk("release_out_valid", bus.out_valid, 0);
        chk("release_in_ready", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        chk("held_input_accepted", bus.in_ready, 0);
        wait_out(lat);
        chk("latency_held", lat, 33);
        chk("held_result", $signed(bus.out_data), -124256286);
        tick();

        // Reset in the middle of MAC
        send(16'd5);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        chk("midrst_in_ready", bus.in_ready, 0);
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_out_data", $signed(bus.out_data), 0);
        rst = 1'b0;
        tick();
        chk("midrst_release_in_ready", bus.in_ready, 1);
        stale = 0;
        repeat (40) begin
            if (bus.out_valid === 1'b1) stale++;
            tick();
        end
        chk("no_stale_result", stale, 0);
        xfer(16'd1, r);
        chk("cleared_impulse_0", r, -15);
        xfer(16'd0, r);
        chk("cleared_impulse_1", r, -47);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
